// File: rtl/alu_exec_unit_pkg.sv
// alu_exec_unit_pkg: shared ALU codes, decode constants and state types
package alu_exec_unit_pkg;
  localparam logic [1:0] ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_RTYPE = 2'b10, ALU_IMM = 2'b11;
  localparam logic [5:0] F_SLL = 6'd0, F_SRL = 6'd2, F_MFHI = 6'd16, F_MFLO = 6'd18,
                         F_MULT = 6'd24, F_MULTU = 6'd25, F_DIV = 6'd26, F_DIVU = 6'd27,
                         F_ADD = 6'd32, F_SUB = 6'd34, F_AND = 6'd36, F_OR = 6'd37,
                         F_XOR = 6'd38, F_NOR = 6'd39, F_SLT = 6'd42;
  localparam logic [5:0] O_ADDI = 6'd8, O_SLTI = 6'd10, O_ANDI = 6'd12, O_ORI = 6'd13,
                         O_XORI = 6'd14, O_LUI = 6'd15;
  typedef enum logic [4:0] {
    OP_AND, OP_OR, OP_ADD, OP_SLL, OP_SRL, OP_LUI, OP_SUB, OP_SLT, OP_NOR, OP_XOR,
    OP_MUL, OP_MULU, OP_DIV, OP_DIVU, OP_MFHI, OP_MFLO, OP_ILL
  } op_t;
  typedef enum logic [1:0] {IDLE, EXEC, ITER, FIX} state_t;
  typedef enum logic [1:0] {MD_IDLE, MD_ITER, MD_FIX} md_state_t;
  function automatic logic is_muldiv(input op_t o);
    return o inside {OP_MUL, OP_MULU, OP_DIV, OP_DIVU};
  endfunction
endpackage

// File: rtl/alu_exec_unit_muldiv_iter.sv
// muldiv_iter: iterative shift-add multiplier and restoring divider with sign fix-up
module muldiv_iter
  import alu_exec_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             done
);
  localparam int CW = $clog2(WIDTH);
  md_state_t st;
  logic [CW-1:0] cnt;
  logic [2*WIDTH-1:0] acc, step, prod;
  logic [WIDTH-1:0] mb, ra, ma_in, mb_in;
  logic [WIDTH:0] sum, trial;
  logic dv, neg_q, neg_r, dz;
  // one iteration step and the sign-corrected view of the finished accumulator
  always_comb begin
    ma_in = (is_signed && a[WIDTH-1]) ? -a : a;
    mb_in = (is_signed && b[WIDTH-1]) ? -b : b;
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, acc[0] ? mb : {WIDTH{1'b0}}};
    trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, mb};
    step = dv ? {trial[WIDTH] ? {acc[2*WIDTH-2:WIDTH], acc[WIDTH-1]} : trial[WIDTH-1:0],
                 acc[WIDTH-2:0], ~trial[WIDTH]}
              : {sum, acc[WIDTH-1:1]};
    prod = neg_q ? -acc : acc;
    hi = dz ? ra : dv ? (neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH]) : prod[2*WIDTH-1:WIDTH];
    lo = dz ? {WIDTH{1'b1}} : dv ? (neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]) : prod[WIDTH-1:0];
    done = st == MD_FIX;
  end
  // operand latch, WIDTH-step iteration counter, then one FIX cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= MD_IDLE;
      cnt <= '0;
      acc <= '0;
      mb <= '0;
      ra <= '0;
      dv <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz <= 1'b0;
    end else if (start) begin
      acc <= {{WIDTH{1'b0}}, ma_in};
      mb <= mb_in;
      ra <= a;
      dv <= is_div;
      neg_q <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_r <= is_signed && a[WIDTH-1];
      dz <= is_div && b == '0;
      cnt <= '0;
      st <= (is_div && b == '0) ? MD_FIX : MD_ITER;
    end else if (st == MD_ITER) begin
      acc <= step;
      cnt <= cnt + 1'b1;
      if (cnt == CW'(WIDTH - 1)) st <= MD_FIX;
    end else if (st == MD_FIX) begin
      st <= MD_IDLE;
    end
  end
endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: decodes ALUOp/opcode/funct and executes single-cycle and mul/div ops
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int SHW       = 5,
  parameter bit MULDIV_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             illegal
);
  function automatic op_t decode(input logic [1:0] ao, input logic [5:0] opc, input logic [5:0] fn);
    op_t o;
    o = OP_ILL;
    case (ao)
      ALU_ADD: o = OP_ADD;
      ALU_SUB: o = OP_SUB;
      ALU_IMM:
        case (opc)
          O_LUI:   o = OP_LUI;
          O_SLTI:  o = OP_SLT;
          O_ADDI:  o = OP_ADD;
          O_ANDI:  o = OP_AND;
          O_ORI:   o = OP_OR;
          O_XORI:  o = OP_XOR;
          default: o = OP_ILL;
        endcase
      default:
        case (fn)
          F_AND:   o = OP_AND;
          F_OR:    o = OP_OR;
          F_ADD:   o = OP_ADD;
          F_SUB:   o = OP_SUB;
          F_SLT:   o = OP_SLT;
          F_NOR:   o = OP_NOR;
          F_XOR:   o = OP_XOR;
          F_SLL:   o = OP_SLL;
          F_SRL:   o = OP_SRL;
          F_MFHI:  o = OP_MFHI;
          F_MFLO:  o = OP_MFLO;
          F_MULT:  o = OP_MUL;
          F_MULTU: o = OP_MULU;
          F_DIV:   o = OP_DIV;
          F_DIVU:  o = OP_DIVU;
          default: o = OP_ILL;
        endcase
    endcase
    return (!MULDIV_EN && is_muldiv(o)) ? OP_ILL : o;
  endfunction
  state_t state, nxt;
  op_t dec, op_q;
  logic [WIDTH-1:0] a_q, b_q, ex, mhi, mlo;
  logic [SHW-1:0] sh_q;
  logic md, mdone;
  // decode of the live inputs and next-state selection
  always_comb begin
    dec = decode(alu_op, opcode, funct);
    md = is_muldiv(dec);
    nxt = state == IDLE ? (start ? (md ? ITER : EXEC) : IDLE)
        : state == EXEC ? IDLE
        : state == ITER ? (mdone ? FIX : ITER)
        : IDLE;
    busy = state != IDLE;
  end
  // single-cycle execution on the operands captured at the start edge
  always_comb begin
    ex = '0;
    case (op_q)
      OP_AND:  ex = a_q & b_q;
      OP_OR:   ex = a_q | b_q;
      OP_ADD:  ex = a_q + b_q;
      OP_SUB:  ex = a_q - b_q;
      OP_NOR:  ex = ~(a_q | b_q);
      OP_XOR:  ex = a_q ^ b_q;
      OP_SLT:  ex = {{(WIDTH-1){1'b0}}, $signed(a_q) < $signed(b_q)};
      OP_SLL:  ex = b_q << sh_q;
      OP_SRL:  ex = b_q >> sh_q;
      OP_LUI:  ex = b_q << (WIDTH / 2);
      OP_MFHI: ex = hi;
      OP_MFLO: ex = lo;
      default: ex = '0;
    endcase
  end
  muldiv_iter #(.WIDTH(WIDTH)) u_md (
    .clk(clk),
    .rst(rst),
    .start(state == IDLE && start && md),
    .is_div(dec == OP_DIV || dec == OP_DIVU),
    .is_signed(dec == OP_MUL || dec == OP_DIV),
    .a(a),
    .b(b),
    .hi(mhi),
    .lo(mlo),
    .done(mdone)
  );
  // control state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= nxt;
  end
  // operand capture and registered result/hi/lo/status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q <= OP_AND;
      a_q <= '0;
      b_q <= '0;
      sh_q <= '0;
      result <= '0;
      zero <= 1'b1;
      hi <= '0;
      lo <= '0;
      done <= 1'b0;
      illegal <= 1'b0;
    end else begin
      done <= 1'b0;
      illegal <= 1'b0;
      if (state == IDLE && start) begin
        op_q <= dec;
        a_q <= a;
        b_q <= b;
        sh_q <= shamt;
      end
      if (state == EXEC) begin
        result <= ex;
        zero <= ex == '0;
        done <= 1'b1;
        illegal <= op_q == OP_ILL;
      end
      if (state == FIX) begin
        hi <= mhi;
        lo <= mlo;
        done <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed self-checking bench for alu_exec_unit
module tb_alu_exec_unit;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, start2 = 1'b0;
  logic [1:0] alu_op = '0;
  logic [5:0] opcode = '0, funct = '0;
  logic [31:0] a = '0, b = '0;
  logic [4:0] shamt = '0;
  logic [31:0] result, hi, lo;
  logic zero, busy, done, illegal;
  logic [15:0] result2, hi2, lo2;
  logic zero2, busy2, done2, illegal2;
  int nvec = 0, nerr = 0, lat;
  logic bhi;
  typedef struct packed {
    logic [1:0] ao;
    logic [5:0] opc;
    logic [5:0] fn;
    logic [31:0] va;
    logic [31:0] vb;
    logic [4:0] sh;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[17];

  always #5 clk = ~clk;

  alu_exec_unit dut (
    .clk(clk), .rst(rst), .start(start), .alu_op(alu_op), .opcode(opcode), .funct(funct),
    .a(a), .b(b), .shamt(shamt), .result(result), .zero(zero), .hi(hi), .lo(lo),
    .busy(busy), .done(done), .illegal(illegal)
  );

  alu_exec_unit #(.WIDTH(16), .SHW(4), .MULDIV_EN(1'b0)) dut16 (
    .clk(clk), .rst(rst), .start(start2), .alu_op(alu_op), .opcode(opcode), .funct(funct),
    .a(a[15:0]), .b(b[15:0]), .shamt(shamt[3:0]), .result(result2), .zero(zero2), .hi(hi2), .lo(lo2),
    .busy(busy2), .done(done2), .illegal(illegal2)
  );

  task automatic run_op(input logic [1:0] ao, input logic [5:0] opc, input logic [5:0] fn,
                        input logic [31:0] aa, input logic [31:0] bb, input logic [4:0] sh);
    @(negedge clk);
    alu_op = ao; opcode = opc; funct = fn; a = aa; b = bb; shamt = sh; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 32'hDEADBEEF; b = 32'hCAFEF00D; shamt = 5'd7; funct = 6'd5;
    lat = 0;
    bhi = busy;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
      if (!done && !busy) bhi = 1'b0;
    end
    if (!done) lat = -1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    nvec++; if (result !== 32'h0 || zero !== 1'b1) begin nerr++; $display("FAIL reset_result got=%h/%b exp=00000000/1", result, zero); end
    nvec++; if (hi !== 32'h0 || lo !== 32'h0) begin nerr++; $display("FAIL reset_hilo got=%h/%h exp=0/0", hi, lo); end
    nvec++; if (busy !== 1'b0 || done !== 1'b0 || illegal !== 1'b0) begin nerr++; $display("FAIL reset_flags got=%b%b%b exp=000", busy, done, illegal); end
    rst = 1'b0;
  endtask

  task automatic test_slt();
    run_op(2'b10, 6'd0, 6'd42, 32'hFFFFFFFF, 32'h1, 5'd0);
    nvec++; if (lat !== 1) begin nerr++; $display("FAIL slt_latency got=%0d exp=1", lat); end
    nvec++; if (result !== 32'h1 || zero !== 1'b0) begin nerr++; $display("FAIL slt_result got=%h/%b exp=00000001/0", result, zero); end
    nvec++; if (illegal !== 1'b0) begin nerr++; $display("FAIL slt_illegal got=%b exp=0", illegal); end
    @(negedge clk);
    nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_lui();
    run_op(2'b11, 6'd15, 6'd0, 32'h0, 32'h00001234, 5'd0);
    nvec++; if (lat !== 1 || result !== 32'h12340000) begin nerr++; $display("FAIL lui got=%0d/%h exp=1/12340000", lat, result); end
  endtask

  task automatic test_alu_table();
    tbl[0]  = '{2'b00, 6'd0,  6'd0,  32'h00000007, 32'hFFFFFFFF, 5'd0,  32'h00000006};
    tbl[1]  = '{2'b01, 6'd0,  6'd0,  32'h00000005, 32'h00000007, 5'd0,  32'hFFFFFFFE};
    tbl[2]  = '{2'b10, 6'd0,  6'd32, 32'h7FFFFFFF, 32'h00000001, 5'd0,  32'h80000000};
    tbl[3]  = '{2'b10, 6'd0,  6'd34, 32'h12345678, 32'h12345678, 5'd0,  32'h00000000};
    tbl[4]  = '{2'b10, 6'd0,  6'd36, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'hF000F000};
    tbl[5]  = '{2'b10, 6'd0,  6'd37, 32'hF0F0F0F0, 32'h0F000000, 5'd0,  32'hFFF0F0F0};
    tbl[6]  = '{2'b10, 6'd0,  6'd39, 32'hF0F0F0F0, 32'h0000000F, 5'd0,  32'h0F0F0F00};
    tbl[7]  = '{2'b10, 6'd0,  6'd38, 32'hFFFF0000, 32'h0F0F0F0F, 5'd0,  32'hF0F00F0F};
    tbl[8]  = '{2'b10, 6'd0,  6'd0,  32'h0,        32'h00000001, 5'd31, 32'h80000000};
    tbl[9]  = '{2'b10, 6'd0,  6'd2,  32'h0,        32'h80000000, 5'd31, 32'h00000001};
    tbl[10] = '{2'b11, 6'd10, 6'd0,  32'h00000005, 32'hFFFFFFFF, 5'd0,  32'h00000000};
    tbl[11] = '{2'b11, 6'd8,  6'd0,  32'hFFFFFFFF, 32'h00000002, 5'd0,  32'h00000001};
    tbl[12] = '{2'b11, 6'd12, 6'd0,  32'h1234ABCD, 32'h0000FFFF, 5'd0,  32'h0000ABCD};
    tbl[13] = '{2'b11, 6'd13, 6'd0,  32'h12340000, 32'h0000FFFF, 5'd0,  32'h1234FFFF};
    tbl[14] = '{2'b11, 6'd14, 6'd0,  32'hFFFFFFFF, 32'h0000FFFF, 5'd0,  32'hFFFF0000};
    tbl[15] = '{2'b10, 6'd0,  6'd42, 32'h00000001, 32'hFFFFFFFF, 5'd0,  32'h00000000};
    tbl[16] = '{2'b10, 6'd0,  6'd2,  32'h0,        32'hF0000000, 5'd4,  32'h0F000000};
    for (int i = 0; i < 17; i++) begin
      run_op(tbl[i].ao, tbl[i].opc, tbl[i].fn, tbl[i].va, tbl[i].vb, tbl[i].sh);
      nvec++;
      if (lat !== 1 || result !== tbl[i].exp || zero !== (tbl[i].exp == 32'h0) || illegal !== 1'b0) begin
        nerr++;
        $display("FAIL alu_vec%0d got lat=%0d res=%h z=%b ill=%b exp lat=1 res=%h z=%b ill=0",
                 i, lat, result, zero, illegal, tbl[i].exp, tbl[i].exp == 32'h0);
      end
    end
  endtask

  task automatic test_mult();
    run_op(2'b00, 6'd0, 6'd0, 32'h00000050, 32'h00000005, 5'd0);
    run_op(2'b10, 6'd0, 6'd24, 32'hFFFFFFFE, 32'h00000003, 5'd0);
    nvec++; if (lat !== 34) begin nerr++; $display("FAIL mult_latency got=%0d exp=34", lat); end
    nvec++; if (bhi !== 1'b1) begin nerr++; $display("FAIL mult_busy got=%b exp=1", bhi); end
    nvec++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFA) begin nerr++; $display("FAIL mult_hilo got=%h_%h exp=FFFFFFFF_FFFFFFFA", hi, lo); end
    nvec++; if (result !== 32'h00000055 || zero !== 1'b0) begin nerr++; $display("FAIL mult_result_held got=%h/%b exp=00000055/0", result, zero); end
    run_op(2'b10, 6'd0, 6'd25, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0);
    nvec++; if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin nerr++; $display("FAIL multu_hilo got=%h_%h exp=FFFFFFFE_00000001", hi, lo); end
  endtask

  task automatic test_div();
    run_op(2'b10, 6'd0, 6'd26, 32'hFFFFFFF9, 32'h00000002, 5'd0);
    nvec++; if (lat !== 34 || lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF) begin nerr++; $display("FAIL div_neg got lat=%0d hi=%h lo=%h exp 34 FFFFFFFF FFFFFFFD", lat, hi, lo); end
    run_op(2'b10, 6'd0, 6'd27, 32'h00000005, 32'h00000000, 5'd0);
    nvec++; if (lat !== 2 || hi !== 32'h00000005 || lo !== 32'hFFFFFFFF) begin nerr++; $display("FAIL divu_zero got lat=%0d hi=%h lo=%h exp 2 00000005 FFFFFFFF", lat, hi, lo); end
    nvec++; if (illegal !== 1'b0) begin nerr++; $display("FAIL divu_zero_illegal got=%b exp=0", illegal); end
    run_op(2'b10, 6'd0, 6'd26, 32'h80000000, 32'hFFFFFFFF, 5'd0);
    nvec++; if (hi !== 32'h0 || lo !== 32'h80000000) begin nerr++; $display("FAIL div_minint got hi=%h lo=%h exp 00000000 80000000", hi, lo); end
    run_op(2'b10, 6'd0, 6'd27, 32'h00000064, 32'h00000007, 5'd0);
    nvec++; if (hi !== 32'h2 || lo !== 32'hE) begin nerr++; $display("FAIL divu got hi=%h lo=%h exp 00000002 0000000E", hi, lo); end
    run_op(2'b10, 6'd0, 6'd26, 32'h00000007, 32'hFFFFFFFE, 5'd0);
    nvec++; if (hi !== 32'h1 || lo !== 32'hFFFFFFFD) begin nerr++; $display("FAIL div_negdivisor got hi=%h lo=%h exp 00000001 FFFFFFFD", hi, lo); end
  endtask

  task automatic test_mfhi_mflo();
    run_op(2'b10, 6'd0, 6'd16, 32'h0, 32'h0, 5'd0);
    nvec++; if (lat !== 1 || result !== 32'h00000001) begin nerr++; $display("FAIL mfhi got=%0d/%h exp=1/00000001", lat, result); end
    run_op(2'b10, 6'd0, 6'd18, 32'h0, 32'h0, 5'd0);
    nvec++; if (result !== 32'hFFFFFFFD) begin nerr++; $display("FAIL mflo got=%h exp=FFFFFFFD", result); end
  endtask

  task automatic test_back_to_back();
    run_op(2'b00, 6'd0, 6'd0, 32'h00000010, 32'h00000020, 5'd0);
    nvec++; if (result !== 32'h00000030) begin nerr++; $display("FAIL b2b_first got=%h exp=00000030", result); end
    run_op(2'b01, 6'd0, 6'd0, 32'h00000030, 32'h00000030, 5'd0);
    nvec++; if (lat !== 1 || result !== 32'h0 || zero !== 1'b1) begin nerr++; $display("FAIL b2b_second got=%0d/%h/%b exp=1/00000000/1", lat, result, zero); end
  endtask

  task automatic test_illegal();
    run_op(2'b00, 6'd0, 6'd0, 32'h00000001, 32'h00000001, 5'd0);
    run_op(2'b10, 6'd0, 6'd5, 32'h11111111, 32'h22222222, 5'd0);
    nvec++; if (lat !== 1 || illegal !== 1'b1) begin nerr++; $display("FAIL illegal_funct got lat=%0d ill=%b exp 1 1", lat, illegal); end
    nvec++; if (result !== 32'h0 || zero !== 1'b1) begin nerr++; $display("FAIL illegal_result got=%h/%b exp=00000000/1", result, zero); end
    nvec++; if (hi !== 32'h1 || lo !== 32'hFFFFFFFD) begin nerr++; $display("FAIL illegal_hilo got=%h/%h exp=00000001/FFFFFFFD", hi, lo); end
    @(negedge clk);
    nvec++; if (illegal !== 1'b0) begin nerr++; $display("FAIL illegal_pulse got=%b exp=0", illegal); end
    run_op(2'b11, 6'd4, 6'd0, 32'h3, 32'h4, 5'd0);
    nvec++; if (illegal !== 1'b1 || result !== 32'h0) begin nerr++; $display("FAIL illegal_opcode got ill=%b res=%h exp 1 00000000", illegal, result); end
  endtask

  task automatic test_no_muldiv();
    @(negedge clk);
    alu_op = 2'b10; funct = 6'd24; a = 32'h0000FFFE; b = 32'h00000003; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    nvec++; if (done2 !== 1'b0 || busy2 !== 1'b1) begin nerr++; $display("FAIL nomd_edge0 got done=%b busy=%b exp 0 1", done2, busy2); end
    @(negedge clk);
    nvec++; if (done2 !== 1'b1 || illegal2 !== 1'b1) begin nerr++; $display("FAIL nomd_illegal got done=%b ill=%b exp 1 1", done2, illegal2); end
    nvec++; if (hi2 !== 16'h0 || lo2 !== 16'h0 || result2 !== 16'h0) begin nerr++; $display("FAIL nomd_values got hi=%h lo=%h res=%h exp 0 0 0", hi2, lo2, result2); end
  endtask

  task automatic test_abort();
    logic seen;
    @(negedge clk);
    alu_op = 2'b10; funct = 6'd25; a = 32'hFFFFFFFF; b = 32'h2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    funct = 6'd32; a = 32'h1; b = 32'h1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nvec++; if (busy !== 1'b1 || done !== 1'b0) begin nerr++; $display("FAIL ignore_start got busy=%b done=%b exp 1 0", busy, done); end
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    nvec++; if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin nerr++; $display("FAIL abort_reset got busy=%b hi=%h lo=%h exp 0 0 0", busy, hi, lo); end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    nvec++; if (seen !== 1'b0) begin nerr++; $display("FAIL abort_no_done got=%b exp=0", seen); end
    run_op(2'b00, 6'd0, 6'd0, 32'h00000002, 32'h00000003, 5'd0);
    nvec++; if (lat !== 1 || result !== 32'h5) begin nerr++; $display("FAIL after_abort got=%0d/%h exp=1/00000005", lat, result); end
  endtask

  initial begin
    test_reset();
    test_slt();
    test_lui();
    test_alu_table();
    test_mult();
    test_div();
    test_mfhi_mflo();
    test_back_to_back();
    test_illegal();
    test_no_muldiv();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
